oled_spi_rx: RTL and testbench
==============================

OLED_SPI_RX -- requirements
Module: oled_spi_rx

Interface
REQ-001 Parameter C_x_size, default 96, pixel columns of the emulated SSD1331 panel.
REQ-002 Parameter C_y_size, default 64, pixel rows of the emulated SSD1331 panel.
REQ-003 clk  input  1  system clock; all logic is in this domain; one clock only.
REQ-004 resn  input  1  reset, asynchronous and active-low.
REQ-005 oled_csn  input  1  SPI chip select, active-low, asynchronous to clk.
REQ-006 oled_clk  input  1  SPI clock, idle high, data sampled on rising edge, asynchronous to clk.
REQ-007 oled_mosi  input  1  SPI data, MSB first.
REQ-008 oled_dc  input  1  0 = command/argument byte, 1 = pixel data byte.
REQ-009 x  output  $clog2(C_x_size)  column of the current pixel write.
REQ-010 y  output  $clog2(C_y_size)  row of the current pixel write.
REQ-011 color  output  16  RGB565 pixel: first data byte in [15:8], second in [7:0].
REQ-012 pixel_we  output  1  one-clk pulse; x, y and color are valid while it is high.
REQ-013 cmd  output  8  last complete command opcode.
REQ-014 cmd_valid  output  1  one-clk pulse on every opcode byte, after any arguments are received.

Function
REQ-015 oled_csn, oled_clk, oled_mosi and oled_dc each pass through a 2-FF synchronizer; a third register on the synchronized oled_clk detects rising edges.
REQ-016 Supported SPI clock rate: at most clk/4.
REQ-017 On each detected oled_clk rising edge while synchronized csn = 0, shift in mosi and increment a 3-bit bit counter.
REQ-018 When the 8th bit is shifted in, the byte is complete; dc is latched with that 8th bit.
REQ-019 Synchronized csn = 1 clears the bit counter; a partial byte is discarded.
REQ-020 csn = 1 does not alter the pixel byte phase, the parser state or the window.
REQ-021 Parser states: CMD (expecting an opcode), ARG (args_left > 0 still to be received).
REQ-022 In CMD, a dc = 0 byte is the opcode; args_left is set from a table.
REQ-023 Argument table: 0x15 and 0x75 take 2 arguments; 0xB8 takes 32 arguments.
REQ-024 Argument table: 0x81, 0x82, 0x83, 0x87, 0x8A, 0x8B, 0x8C, 0xA0, 0xA1, 0xA2, 0xA8, 0xAD, 0xB0, 0xB1, 0xB3, 0xBB and 0xBE take 1 argument.
REQ-025 Argument table: every other opcode takes 0 arguments.
REQ-026 cmd_valid pulses after the opcode byte when the opcode takes 0 arguments.
REQ-027 cmd_valid pulses after the last argument byte when the opcode takes arguments.
REQ-028 On the same cycle as REQ-026/REQ-027, the parser returns to CMD.
REQ-029 In ARG, each dc = 0 byte decrements args_left.
REQ-030 A dc = 1 byte received in ARG aborts the command: no cmd_valid pulse, return to CMD, then process the byte as pixel data.
REQ-031 Argument 1 of 0x15 sets col_start; argument 2 sets col_end.
REQ-032 Argument 1 of 0x75 sets row_start; argument 2 sets row_end.
REQ-033 Column arguments greater than C_x_size-1 clamp to C_x_size-1; row arguments greater than C_y_size-1 clamp to C_y_size-1.
REQ-034 Completion of 0x15 loads x = col_start; completion of 0x75 loads y = row_start.
REQ-035 Any dc = 0 byte clears the pixel byte phase to "high byte next".
REQ-036 Pixel data: a dc = 1 byte in high phase is stored as color[15:8] and the phase toggles.
REQ-037 Pixel data: a dc = 1 byte in low phase forms color[7:0]; pixel_we pulses with the current x and y, and the phase toggles.
REQ-038 Latency: pixel_we and cmd_valid assert exactly 4 clk cycles after the oled_clk rising edge carrying the byte's last bit.
REQ-039 The cycle after pixel_we, advance the write position as follows.
REQ-040 Advance: if x ≠ col_end, x = x+1.
REQ-041 Advance: else x = col_start; then y = y+1 if y ≠ row_end, else y = row_start.
REQ-042 If start > end for a window, the comparison against end never matches; x or y wraps at the panel size (C_x_size-1 → 0, C_y_size-1 → 0) until it reaches end.

Reset
REQ-043 resn = 0 asynchronously clears: synchronizers (csn sync set to 1, clk sync set to 1), bit counter, shift register, parser (CMD, args_left = 0), pixel phase (high), x, y, color, cmd, pixel_we and cmd_valid.
REQ-044 Reset window values: col_start = 0, col_end = C_x_size-1, row_start = 0, row_end = C_y_size-1.
REQ-045 Reset asserted mid-byte or mid-command discards all partial state; reception restarts from the next byte after resn = 1 and csn high→low.

Verification
REQ-046 Send dc = 1 bytes 0xF8 0x00 after reset -> one pixel_we with x = 0, y = 0, color = 0xF800, 4 clk after the last edge.
REQ-047 Send 96×64×2 data bytes -> 6144 pixel_we pulses; after (95,0) comes (0,1); after (95,63) comes (0,0).
REQ-048 Send cmd 0x15,0x10,0x12 and 0x75,0x05,0x06, then 8 pixels -> positions (16,5) (17,5) (18,5) (16,6) (17,6) (18,6) (16,5) (17,5).
REQ-049 Send 0x15,0xFF,0xFF -> col_start = col_end = 95; each following pixel has x = 95.
REQ-050 Drop csn after 5 bits, then send 0xAF with dc = 0 -> no pixel_we, cmd = 0xAF, one cmd_valid.
REQ-051 Send one data byte, then cmd 0xA0,0x72, then 0x12,0x34 as data -> cmd_valid with cmd = 0xA0; pixel color = 0x1234 (phase reset).

Source files
------------

// File: rtl/oled_spi_rx_if.sv
// Pin-level SPI inputs and decoded pixel/command outputs of the SSD1331 receiver.
interface oled_spi_rx_if #(
    parameter int C_x_size = 96,
    parameter int C_y_size = 64
);
    localparam int XW = $clog2(C_x_size);
    localparam int YW = $clog2(C_y_size);

    logic          oled_csn;
    logic          oled_clk;
    logic          oled_mosi;
    logic          oled_dc;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [15:0]   color;
    logic          pixel_we;
    logic [7:0]    cmd;
    logic          cmd_valid;

    modport master (
        output oled_csn, oled_clk, oled_mosi, oled_dc,
        input  x, y, color, pixel_we, cmd, cmd_valid
    );

    modport slave (
        input  oled_csn, oled_clk, oled_mosi, oled_dc,
        output x, y, color, pixel_we, cmd, cmd_valid
    );
endinterface

// File: rtl/oled_spi_rx.sv
// SSD1331 SPI slave emulator: oversamples the SPI pins, parses commands and
// emits RGB565 pixel writes with the panel's column/row window addressing.
module oled_spi_rx #(
    parameter int C_x_size = 96,
    parameter int C_y_size = 64
) (
    input  logic         clk,
    input  logic         resn,
    oled_spi_rx_if.slave bus
);
    localparam int XW = $clog2(C_x_size);
    localparam int YW = $clog2(C_y_size);
    localparam logic [XW-1:0] XMAX = XW'(C_x_size - 1);
    localparam logic [YW-1:0] YMAX = YW'(C_y_size - 1);

    typedef enum logic [0:0] {StCmd, StArg} state_e;

    // Byte assembler
    logic [1:0] r_csn_s, r_mosi_s, r_dc_s;
    logic [2:0] r_clk_s;
    logic [2:0] r_bit_cnt;
    logic [7:0] r_shift;
    logic       r_byte_vld, r_byte_dc;
    logic       w_csn, w_rise;

    assign w_csn  = r_csn_s[1];
    assign w_rise = r_clk_s[1] & ~r_clk_s[2];

    always_ff @(posedge clk or negedge resn) begin
        if (!resn) begin
            r_csn_s    <= 2'b11;
            r_clk_s    <= 3'b111;
            r_mosi_s   <= 2'b00;
            r_dc_s     <= 2'b00;
            r_bit_cnt  <= 3'd0;
            r_shift    <= 8'h00;
            r_byte_vld <= 1'b0;
            r_byte_dc  <= 1'b0;
        end else begin
            r_csn_s    <= {r_csn_s[0], bus.oled_csn};
            r_clk_s    <= {r_clk_s[1:0], bus.oled_clk};
            r_mosi_s   <= {r_mosi_s[0], bus.oled_mosi};
            r_dc_s     <= {r_dc_s[0], bus.oled_dc};
            r_byte_vld <= 1'b0;
            if (w_csn) begin
                r_bit_cnt <= 3'd0;
            end else if (w_rise) begin
                r_shift   <= {r_shift[6:0], r_mosi_s[1]};
                r_bit_cnt <= r_bit_cnt + 3'd1;
                if (r_bit_cnt == 3'd7) begin
                    r_byte_vld <= 1'b1;
                    r_byte_dc  <= r_dc_s[1];
                end
            end
        end
    end

    function automatic logic [5:0] f_num_args(input logic [7:0] op);
        case (op)
            8'h15, 8'h75: f_num_args = 6'd2;
            8'hB8:        f_num_args = 6'd32;
            8'h81, 8'h82, 8'h83, 8'h87, 8'h8A, 8'h8B, 8'h8C, 8'hA0, 8'hA1,
            8'hA2, 8'hA8, 8'hAD, 8'hB0, 8'hB1, 8'hB3, 8'hBB, 8'hBE:
                          f_num_args = 6'd1;
            default:      f_num_args = 6'd0;
        endcase
    endfunction

    function automatic logic [XW-1:0] f_clamp_x(input logic [7:0] v);
        return (int'(v) > C_x_size - 1) ? XMAX : XW'(v);
    endfunction

    function automatic logic [YW-1:0] f_clamp_y(input logic [7:0] v);
        return (int'(v) > C_y_size - 1) ? YMAX : YW'(v);
    endfunction

    // Parser and pixel addressing
    state_e        r_state, w_state_nxt;
    logic [5:0]    r_args_left, w_args_left_nxt;
    logic [7:0]    r_op, w_op_nxt;
    logic [7:0]    r_cmd, w_cmd_nxt;
    logic          r_phase, w_phase_nxt;
    logic [15:0]   r_color, w_color_nxt;
    logic [XW-1:0] r_x, w_x_nxt, r_cs, w_cs_nxt, r_ce, w_ce_nxt;
    logic [YW-1:0] r_y, w_y_nxt, r_rs, w_rs_nxt, r_re, w_re_nxt;
    logic          r_pixel_we, w_pixel_we_nxt;
    logic          r_cmd_valid, w_cmd_valid_nxt;
    logic [5:0]    w_nargs;

    assign w_nargs = f_num_args(r_shift);

    always_comb begin
        w_state_nxt     = r_state;
        w_args_left_nxt = r_args_left;
        w_op_nxt        = r_op;
        w_cmd_nxt       = r_cmd;
        w_phase_nxt     = r_phase;
        w_color_nxt     = r_color;
        w_x_nxt         = r_x;
        w_y_nxt         = r_y;
        w_cs_nxt        = r_cs;
        w_ce_nxt        = r_ce;
        w_rs_nxt        = r_rs;
        w_re_nxt        = r_re;
        w_pixel_we_nxt  = 1'b0;
        w_cmd_valid_nxt = 1'b0;

        // Post-write advance; an inverted window never matches end and wraps at the panel edge.
        if (r_pixel_we) begin
            if (r_x != r_ce) begin
                w_x_nxt = (r_x == XMAX) ? '0 : r_x + 1'b1;
            end else begin
                w_x_nxt = r_cs;
                if (r_y != r_re) w_y_nxt = (r_y == YMAX) ? '0 : r_y + 1'b1;
                else             w_y_nxt = r_rs;
            end
        end

        if (r_byte_vld) begin
            if (!r_byte_dc) begin
                w_phase_nxt = 1'b0;
                case (r_state)
                    StCmd: begin
                        w_op_nxt        = r_shift;
                        w_args_left_nxt = w_nargs;
                        if (w_nargs == 6'd0) begin
                            w_cmd_nxt       = r_shift;
                            w_cmd_valid_nxt = 1'b1;
                        end else begin
                            w_state_nxt = StArg;
                        end
                    end
                    StArg: begin
                        w_args_left_nxt = r_args_left - 6'd1;
                        if (r_op == 8'h15) begin
                            if (r_args_left == 6'd2) w_cs_nxt = f_clamp_x(r_shift);
                            else                     w_ce_nxt = f_clamp_x(r_shift);
                        end
                        if (r_op == 8'h75) begin
                            if (r_args_left == 6'd2) w_rs_nxt = f_clamp_y(r_shift);
                            else                     w_re_nxt = f_clamp_y(r_shift);
                        end
                        if (r_args_left == 6'd1) begin
                            w_state_nxt     = StCmd;
                            w_cmd_nxt       = r_op;
                            w_cmd_valid_nxt = 1'b1;
                            if (r_op == 8'h15) w_x_nxt = r_cs;
                            if (r_op == 8'h75) w_y_nxt = r_rs;
                        end
                    end
                endcase
            end else begin
                // Pixel data aborts any pending argument list.
                w_state_nxt     = StCmd;
                w_args_left_nxt = 6'd0;
                w_phase_nxt     = ~r_phase;
                if (!r_phase) begin
                    w_color_nxt[15:8] = r_shift;
                end else begin
                    w_color_nxt[7:0] = r_shift;
                    w_pixel_we_nxt   = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge resn) begin
        if (!resn) begin
            r_state     <= StCmd;
            r_args_left <= 6'd0;
            r_op        <= 8'h00;
            r_cmd       <= 8'h00;
            r_phase     <= 1'b0;
            r_color     <= 16'h0000;
            r_x         <= '0;
            r_y         <= '0;
            r_cs        <= '0;
            r_ce        <= XMAX;
            r_rs        <= '0;
            r_re        <= YMAX;
            r_pixel_we  <= 1'b0;
            r_cmd_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_args_left <= w_args_left_nxt;
            r_op        <= w_op_nxt;
            r_cmd       <= w_cmd_nxt;
            r_phase     <= w_phase_nxt;
            r_color     <= w_color_nxt;
            r_x         <= w_x_nxt;
            r_y         <= w_y_nxt;
            r_cs        <= w_cs_nxt;
            r_ce        <= w_ce_nxt;
            r_rs        <= w_rs_nxt;
            r_re        <= w_re_nxt;
            r_pixel_we  <= w_pixel_we_nxt;
            r_cmd_valid <= w_cmd_valid_nxt;
        end
    end

    assign bus.x         = r_x;
    assign bus.y         = r_y;
    assign bus.color     = r_color;
    assign bus.pixel_we  = r_pixel_we;
    assign bus.cmd       = r_cmd;
    assign bus.cmd_valid = r_cmd_valid;
endmodule

// File: tb/tb_oled_spi_rx.sv
// Bench for oled_spi_rx: byte-level reference model plus a small-panel instance for frame wrap.
module tb_oled_spi_rx;
    localparam int XS = 96, YS = 64, SXS = 8, SYS = 4;

    logic clk = 1'b0, resn = 1'b0;
    logic csn = 1'b1, sclk = 1'b1, mosi = 1'b0, dc = 1'b0;
    int n_pass = 0, n_total = 0;
    int cyc = 0, last_rise = 0;

    oled_spi_rx_if #(.C_x_size(XS), .C_y_size(YS)) bus ();
    oled_spi_rx_if #(.C_x_size(SXS), .C_y_size(SYS)) sbus ();

    assign bus.oled_csn = csn;   assign sbus.oled_csn = csn;
    assign bus.oled_clk = sclk;  assign sbus.oled_clk = sclk;
    assign bus.oled_mosi = mosi; assign sbus.oled_mosi = mosi;
    assign bus.oled_dc = dc;     assign sbus.oled_dc = dc;

    oled_spi_rx #(.C_x_size(XS), .C_y_size(YS)) dut (.clk(clk), .resn(resn), .bus(bus));
    oled_spi_rx #(.C_x_size(SXS), .C_y_size(SYS)) dut_s (.clk(clk), .resn(resn), .bus(sbus));

    always #5 clk = ~clk;

    typedef struct { int x; int y; int color; int cyc; } pix_t;
    pix_t px_q[$], ex_q[$];
    int sx_q[$], sy_q[$], cm_q[$], cm_cyc[$], ec_q[$];

    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        if (bus.pixel_we)
            px_q.push_back('{int'(bus.x), int'(bus.y), int'(bus.color), cyc});
        if (bus.cmd_valid) begin
            cm_q.push_back(int'(bus.cmd));
            cm_cyc.push_back(cyc);
        end
        if (sbus.pixel_we) begin
            sx_q.push_back(int'(sbus.x));
            sy_q.push_back(int'(sbus.y));
        end
    end

    // Byte-level reference model of the 96x64 panel
    int m_x, m_y, m_cs, m_ce, m_rs, m_re, m_left, m_argn, m_op, m_hi, m_cmd;
    bit m_phase;

    function automatic int nargs(input int op);
        int one [17] = '{'h81, 'h82, 'h83, 'h87, 'h8A, 'h8B, 'h8C, 'hA0, 'hA1,
                         'hA2, 'hA8, 'hAD, 'hB0, 'hB1, 'hB3, 'hBB, 'hBE};
        if (op == 'h15 || op == 'h75) return 2;
        if (op == 'hB8) return 32;
        foreach (one[i]) if (one[i] == op) return 1;
        return 0;
    endfunction

    task automatic model_byte(input bit d, input int b);
        int v;
        if (!d) begin
            m_phase = 1'b0;
            if (m_left == 0) begin
                m_op = b; m_left = nargs(b); m_argn = 0;
                if (m_left == 0) begin ec_q.push_back(b); m_cmd = b; end
            end else begin
                m_argn++; m_left--;
                if (m_op == 'h15) begin
                    v = (b > XS - 1) ? XS - 1 : b;
                    if (m_argn == 1) m_cs = v; else m_ce = v;
                end
                if (m_op == 'h75) begin
                    v = (b > YS - 1) ? YS - 1 : b;
                    if (m_argn == 1) m_rs = v; else m_re = v;
                end
                if (m_left == 0) begin
                    ec_q.push_back(m_op); m_cmd = m_op;
                    if (m_op == 'h15) m_x = m_cs;
                    if (m_op == 'h75) m_y = m_rs;
                end
            end
        end else begin
            m_left = 0;
            if (!m_phase) begin
                m_hi = b;
            end else begin
                ex_q.push_back('{m_x, m_y, m_hi * 256 + b, 0});
                if (m_x != m_ce) begin
                    m_x = (m_x + 1) % XS;
                end else begin
                    m_x = m_cs;
                    m_y = (m_y != m_re) ? (m_y + 1) % YS : m_rs;
                end
            end
            m_phase = !m_phase;
        end
    endtask

    task automatic spi_bit(input bit b, input bit d);
        @(negedge clk); sclk = 1'b0; mosi = b; dc = d;
        repeat (2) @(negedge clk);
        sclk = 1'b1; last_rise = cyc;
        @(negedge clk);
    endtask

    task automatic send_byte(input bit d, input logic [7:0] b);
        for (int i = 7; i >= 0; i--) spi_bit(b[i], d);
        model_byte(d, int'(b));
    endtask

    task automatic cs_low();
        @(negedge clk); csn = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic settle();
        repeat (8) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk); resn = 1'b0; csn = 1'b1; sclk = 1'b1; mosi = 1'b0; dc = 1'b0;
        repeat (3) @(negedge clk);
        resn = 1'b1;
        m_x = 0; m_y = 0; m_cs = 0; m_ce = XS - 1; m_rs = 0; m_re = YS - 1;
        m_left = 0; m_argn = 0; m_op = 0; m_hi = 0; m_cmd = 0; m_phase = 1'b0;
        px_q.delete(); ex_q.delete(); sx_q.delete(); sy_q.delete();
        cm_q.delete(); cm_cyc.delete(); ec_q.delete();
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset(); cs_low();
        send_byte(1'b1, 8'h12); send_byte(1'b1, 8'h34); send_byte(1'b0, 8'hAF);
        spi_bit(1'b1, 1'b1); spi_bit(1'b0, 1'b1); spi_bit(1'b1, 1'b1);
        #2 resn = 1'b0;
        #20;
        n_total++; if (bus.x !== 7'd0) $display("FAIL reset_x: got %0d want 0", bus.x); else n_pass++;
        n_total++; if (bus.y !== 6'd0) $display("FAIL reset_y: got %0d want 0", bus.y); else n_pass++;
        n_total++; if (bus.color !== 16'h0) $display("FAIL reset_color: got %h want 0000", bus.color); else n_pass++;
        n_total++; if (bus.cmd !== 8'h0) $display("FAIL reset_cmd: got %h want 00", bus.cmd); else n_pass++;
        n_total++; if (bus.pixel_we !== 1'b0 || bus.cmd_valid !== 1'b0)
            $display("FAIL reset_pulses: got we=%b cv=%b want 0 0", bus.pixel_we, bus.cmd_valid); else n_pass++;
        do_reset(); cs_low();
        send_byte(1'b1, 8'hAB); send_byte(1'b1, 8'hCD); settle();
        n_total++;
        if (px_q.size() != 1 || px_q[0].color != 'hABCD || px_q[0].x != 0 || px_q[0].y != 0)
            $display("FAIL reset_restart: got n=%0d color=%h want n=1 color=abcd at (0,0)",
                     px_q.size(), (px_q.size() > 0) ? px_q[0].color : -1);
        else n_pass++;
    endtask

    task automatic test_first_pixel();
        do_reset(); cs_low();
        send_byte(1'b1, 8'hF8); send_byte(1'b1, 8'h00); settle();
        n_total++; if (px_q.size() != 1) $display("FAIL first_count: got %0d want 1", px_q.size()); else n_pass++;
        if (px_q.size() > 0) begin
            n_total++; if (px_q[0].x != 0 || px_q[0].y != 0)
                $display("FAIL first_pos: got (%0d,%0d) want (0,0)", px_q[0].x, px_q[0].y); else n_pass++;
            n_total++; if (px_q[0].color != 'hF800)
                $display("FAIL first_color: got %h want f800", px_q[0].color); else n_pass++;
            n_total++; if (px_q[0].cyc - last_rise != 4)
                $display("FAIL first_latency: got %0d want 4", px_q[0].cyc - last_rise); else n_pass++;
        end
        n_total++; if (cm_q.size() != 0) $display("FAIL first_nocmd: got %0d want 0", cm_q.size()); else n_pass++;
    endtask

    task automatic test_frame();
        logic [15:0] c;
        do_reset(); cs_low();
        for (int i = 0; i < 98; i++) begin
            c = 16'($urandom);
            send_byte(1'b1, c[15:8]); send_byte(1'b1, c[7:0]);
        end
        settle();
        n_total++; if (px_q.size() != ex_q.size())
            $display("FAIL frame_count: got %0d want %0d", px_q.size(), ex_q.size()); else n_pass++;
        for (int i = 0; i < ex_q.size() && i < px_q.size(); i++) begin
            n_total++;
            if (px_q[i].x != ex_q[i].x || px_q[i].y != ex_q[i].y || px_q[i].color != ex_q[i].color)
                $display("FAIL frame_pix%0d: got (%0d,%0d,%h) want (%0d,%0d,%h)", i, px_q[i].x,
                         px_q[i].y, px_q[i].color, ex_q[i].x, ex_q[i].y, ex_q[i].color);
            else n_pass++;
        end
        n_total++;
        if (px_q.size() < 97 || px_q[95].x != 95 || px_q[95].y != 0 || px_q[96].x != 0 || px_q[96].y != 1)
            $display("FAIL frame_rowwrap: got n=%0d, want (95,0) then (0,1)", px_q.size());
        else n_pass++;
        n_total++; if (sx_q.size() != 98) $display("FAIL small_count: got %0d want 98", sx_q.size()); else n_pass++;
        for (int i = 0; i < sx_q.size(); i++) begin
            n_total++;
            if (sx_q[i] != i % SXS || sy_q[i] != (i / SXS) % SYS)
                $display("FAIL small_pix%0d: got (%0d,%0d) want (%0d,%0d)", i, sx_q[i], sy_q[i],
                         i % SXS, (i / SXS) % SYS);
            else n_pass++;
        end
    endtask

    task automatic test_window();
        int ex [8] = '{16, 17, 18, 16, 17, 18, 16, 17};
        int ey [8] = '{5, 5, 5, 6, 6, 6, 5, 5};
        do_reset(); cs_low();
        send_byte(1'b0, 8'h15); send_byte(1'b0, 8'h10); send_byte(1'b0, 8'h12);
        send_byte(1'b0, 8'h75); send_byte(1'b0, 8'h05); send_byte(1'b0, 8'h06);
        for (int i = 0; i < 8; i++) begin
            send_byte(1'b1, 8'($urandom)); send_byte(1'b1, 8'($urandom));
        end
        settle();
        n_total++; if (px_q.size() != 8) $display("FAIL win_count: got %0d want 8", px_q.size()); else n_pass++;
        for (int i = 0; i < 8 && i < px_q.size(); i++) begin
            n_total++;
            if (px_q[i].x != ex[i] || px_q[i].y != ey[i] || px_q[i].color != ex_q[i].color)
                $display("FAIL win_pix%0d: got (%0d,%0d,%h) want (%0d,%0d,%h)", i, px_q[i].x,
                         px_q[i].y, px_q[i].color, ex[i], ey[i], ex_q[i].color);
            else n_pass++;
        end
        n_total++;
        if (cm_q.size() != 2 || cm_q[0] != 'h15 || cm_q[1] != 'h75)
            $display("FAIL win_cmds: got n=%0d want 15,75", cm_q.size());
        else n_pass++;
    endtask

    task automatic test_clamp();
        do_reset(); cs_low();
        send_byte(1'b0, 8'h15); send_byte(1'b0, 8'hFF); send_byte(1'b0, 8'hFF);
        for (int i = 0; i < 3; i++) begin
            send_byte(1'b1, 8'($urandom)); send_byte(1'b1, 8'($urandom));
        end
        settle();
        n_total++; if (px_q.size() != 3) $display("FAIL clamp_count: got %0d want 3", px_q.size()); else n_pass++;
        for (int i = 0; i < px_q.size(); i++) begin
            n_total++;
            if (px_q[i].x != 95 || px_q[i].y != i)
                $display("FAIL clamp_pix%0d: got (%0d,%0d) want (95,%0d)", i, px_q[i].x, px_q[i].y, i);
            else n_pass++;
        end
    endtask

    task automatic test_csn_abort();
        logic [4:0] junk;
        do_reset(); cs_low();
        junk = 5'($urandom);
        for (int i = 4; i >= 0; i--) spi_bit(junk[i], 1'b0);
        @(negedge clk); csn = 1'b1;
        repeat (4) @(negedge clk);
        cs_low();
        send_byte(1'b0, 8'hAF); settle();
        n_total++; if (px_q.size() != 0) $display("FAIL csn_nopix: got %0d want 0", px_q.size()); else n_pass++;
        n_total++; if (cm_q.size() != 1) $display("FAIL csn_cmdcount: got %0d want 1", cm_q.size()); else n_pass++;
        n_total++; if (bus.cmd !== 8'hAF) $display("FAIL csn_cmd: got %h want af", bus.cmd); else n_pass++;
        if (cm_cyc.size() > 0) begin
            n_total++; if (cm_cyc[0] - last_rise != 4)
                $display("FAIL csn_latency: got %0d want 4", cm_cyc[0] - last_rise); else n_pass++;
        end
    endtask

    task automatic test_phase_reset();
        do_reset(); cs_low();
        send_byte(1'b1, 8'h55);
        send_byte(1'b0, 8'hA0); send_byte(1'b0, 8'h72);
        send_byte(1'b1, 8'h12); send_byte(1'b1, 8'h34);
        settle();
        n_total++; if (cm_q.size() != 1 || cm_q[0] != 'hA0)
            $display("FAIL phase_cmd: got n=%0d want one a0", cm_q.size()); else n_pass++;
        n_total++;
        if (px_q.size() != 1 || px_q[0].color != 'h1234 || px_q[0].x != 0 || px_q[0].y != 0)
            $display("FAIL phase_pix: got n=%0d color=%h want one 1234 at (0,0)", px_q.size(),
                     (px_q.size() > 0) ? px_q[0].color : -1);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [7:0] ops [13] = '{8'h15, 8'h75, 8'h15, 8'h75, 8'hA0, 8'hAF, 8'hAE,
                                 8'h81, 8'hB8, 8'hBB, 8'hA4, 8'hA6, 8'h25};
        logic [7:0] op;
        int r, na;
        do_reset(); cs_low();
        for (int it = 0; it < 50; it++) begin
            r = $urandom_range(0, 9);
            if (r < 4) begin
                send_byte(1'b1, 8'($urandom));
            end else if (r == 4) begin
                @(negedge clk); csn = 1'b1;
                repeat (3) @(negedge clk);
                cs_low();
            end else begin
                op = ops[$urandom_range(0, 12)];
                send_byte(1'b0, op);
                na = nargs(int'(op));
                if (na > 0 && $urandom_range(0, 3) == 0) na = $urandom_range(0, na - 1);
                for (int a = 0; a < na; a++)
                    send_byte(1'b0, (op == 8'h15 || op == 8'h75) ? 8'($urandom_range(0, 127))
                                                                 : 8'($urandom));
                for (int p = $urandom_range(0, 4); p > 0; p--) begin
                    send_byte(1'b1, 8'($urandom)); send_byte(1'b1, 8'($urandom));
                end
            end
        end
        settle();
        n_total++; if (px_q.size() != ex_q.size())
            $display("FAIL rand_pixcount: got %0d want %0d", px_q.size(), ex_q.size()); else n_pass++;
        for (int i = 0; i < ex_q.size() && i < px_q.size(); i++) begin
            n_total++;
            if (px_q[i].x != ex_q[i].x || px_q[i].y != ex_q[i].y || px_q[i].color != ex_q[i].color)
                $display("FAIL rand_pix%0d: got (%0d,%0d,%h) want (%0d,%0d,%h)", i, px_q[i].x,
                         px_q[i].y, px_q[i].color, ex_q[i].x, ex_q[i].y, ex_q[i].color);
            else n_pass++;
        end
        n_total++; if (cm_q.size() != ec_q.size())
            $display("FAIL rand_cmdcount: got %0d want %0d", cm_q.size(), ec_q.size()); else n_pass++;
        for (int i = 0; i < ec_q.size() && i < cm_q.size(); i++) begin
            n_total++; if (cm_q[i] != ec_q[i])
                $display("FAIL rand_cmd%0d: got %h want %h", i, cm_q[i], ec_q[i]); else n_pass++;
        end
        n_total++; if (int'(bus.x) != m_x || int'(bus.y) != m_y)
            $display("FAIL rand_pos: got (%0d,%0d) want (%0d,%0d)", bus.x, bus.y, m_x, m_y); else n_pass++;
        n_total++; if (int'(bus.cmd) != m_cmd)
            $display("FAIL rand_lastcmd: got %h want %h", bus.cmd, m_cmd); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_first_pixel();
        test_frame();
        test_window();
        test_clamp();
        test_csn_abort();
        test_phase_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #4000000;
        $display("FAIL watchdog: simulation time limit reached after %0d checks", n_total);
        $fatal(1);
    end
endmodule
